// File: rtl/cpu_controller.sv
// cpu_controller: multicycle control FSM for the 16-bit CPU datapath.
//
// Fetches an instruction word from synchronous memory into the instruction
// register (IR), decodes it and steps it through a fixed state sequence.
// All datapath controls are Moore outputs decoded from the current state and
// the IR. A 5-bit flag register (PSR) captures the ALU flags in EXECUTE and
// feeds the conditional branches.
//
// Ports:
//   clk, reset             - clock; synchronous active-high reset
//   memReadData            - memory read data (valid the cycle after address)
//   carryFlag..zeroFlag    - combinational ALU flags
//   aluOpCode, instrType   - ALU operation / register(0) vs immediate(1) form
//   regAddressA/B          - source IR[3:0] / destination IR[11:8]
//   immediate              - IR[7:0] sign-extended
//   *RegEnable             - datapath pipeline register enables
//   aluInputA/BMuxSelect   - 0 = register data, 1 = PC / immediate
//   regWriteEnable/SrcSel  - register-file write strobe and source
//   pcEnable/pcSourceSel   - PC load, 0 = PC+1, 1 = PC+immediate
//   memAddrSelect          - 0 = PC, 1 = regReadData1
//   memWriteEnable         - store strobe
//   halted                 - high while in HALT
module cpu_controller #(
  parameter int REG_WIDTH     = 16,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REG_WIDTH-1:0]     memReadData,
  input  logic                     carryFlag,
  input  logic                     lowFlag,
  input  logic                     overflowFlag,
  input  logic                     negFlag,
  input  logic                     zeroFlag,
  output logic [3:0]               aluOpCode,
  output logic                     instrType,
  output logic [REG_ADDR_BITS-1:0] regAddressA,
  output logic [REG_ADDR_BITS-1:0] regAddressB,
  output logic [REG_WIDTH-1:0]     immediate,
  output logic                     srcAddressRegEnable,
  output logic                     dstAddressRegEnable,
  output logic                     immediateRegEnable,
  output logic                     aluOutputRegEnable,
  output logic                     aluInputAMuxSelect,
  output logic                     aluInputBMuxSelect,
  output logic                     regWriteEnable,
  output logic                     regWriteSrcSelect,
  output logic                     pcEnable,
  output logic                     pcSourceSelect,
  output logic                     memAddrSelect,
  output logic                     memWriteEnable,
  output logic                     halted
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXECUTE   = 4'd2,
    S_WRITEBACK = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_STORE     = 4'd6,
    S_BRANCH    = 4'd7,
    S_HALT      = 4'd8
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] ALU_CMP  = 4'b1011;
  localparam logic [3:0] MEM_LOAD = 4'b0000;
  localparam logic [3:0] MEM_STOR = 4'b0100;
  localparam logic [3:0] COND_EQ  = 4'b0000;
  localparam logic [3:0] COND_NE  = 4'b0001;
  localparam logic [3:0] COND_AL  = 4'b1110;

  state_t               state;
  state_t               next_state;
  logic [REG_WIDTH-1:0] ir;
  logic [4:0]           psr;     // {carry, low, overflow, neg, zero}
  logic [3:0]           ir_op;
  logic                 ir_is_imm;
  logic                 ir_is_cmp;
  logic                 unused_psr_bits;

  // Any opcode outside the four reserved groups is an immediate ALU op.
  function automatic logic is_imm_op(input logic [3:0] op);
    return (op != OP_RTYPE) && (op != OP_MEM) && (op != OP_BCOND) && (op != OP_HALT);
  endfunction

  // State that follows DECODE for a freshly fetched word; illegal encodings halt.
  function automatic state_t decode_target(input logic [15:0] word);
    state_t target;
    case (word[15:12])
      OP_RTYPE: target = S_EXECUTE;
      OP_MEM: begin
        if (word[7:4] == MEM_LOAD) begin
          target = S_MEM_ADDR;
        end else if (word[7:4] == MEM_STOR) begin
          target = S_STORE;
        end else begin
          target = S_HALT;
        end
      end
      OP_BCOND: target = S_BRANCH;
      OP_HALT:  target = S_HALT;
      default:  target = S_EXECUTE;
    endcase
    return target;
  endfunction

  // Branch condition evaluation; unlisted condition codes are never taken.
  function automatic logic branch_taken(input logic [3:0] cond, input logic z);
    logic taken;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  assign ir_op     = ir[15:12];
  assign ir_is_imm = is_imm_op(ir_op);
  // Compare is opcode 1011 in the immediate form, or function 1011 in R-type.
  assign ir_is_cmp = (ir_op == OP_RTYPE) ? (ir[7:4] == ALU_CMP) : (ir_op == ALU_CMP);
  // Only the zero flag steers branches; the rest of PSR is kept as state.
  assign unused_psr_bits = ^psr[4:1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Instruction register and flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir  <= '0;
      psr <= 5'd0;
    end else begin
      if (state == S_DECODE) begin
        ir <= memReadData;
      end
      if (state == S_EXECUTE) begin
        psr <= {carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag};
      end
    end
  end

  // Next-state and Moore output decode; reset forces every output low so an
  // aborted instruction cannot strobe a write in the reset cycle.
  always_comb begin
    next_state          = state;
    aluOpCode           = 4'd0;
    instrType           = 1'b0;
    regAddressA         = '0;
    regAddressB         = '0;
    immediate           = '0;
    srcAddressRegEnable = 1'b0;
    dstAddressRegEnable = 1'b0;
    immediateRegEnable  = 1'b0;
    aluOutputRegEnable  = 1'b0;
    aluInputAMuxSelect  = 1'b0;
    aluInputBMuxSelect  = 1'b0;
    regWriteEnable      = 1'b0;
    regWriteSrcSelect   = 1'b0;
    pcEnable            = 1'b0;
    pcSourceSelect      = 1'b0;
    memAddrSelect       = 1'b0;
    memWriteEnable      = 1'b0;
    halted              = 1'b0;

    if (reset) begin
      next_state = S_FETCH;
    end else begin
      if (ir_op == OP_RTYPE) begin
        aluOpCode = ir[7:4];
      end else if (ir_is_imm) begin
        aluOpCode = ir_op;
      end else begin
        aluOpCode = 4'd0;
      end
      instrType   = ir_is_imm;
      regAddressA = ir[REG_ADDR_BITS-1:0];
      regAddressB = ir[8 +: REG_ADDR_BITS];
      immediate   = {{(REG_WIDTH-8){ir[7]}}, ir[7:0]};

      case (state)
        S_FETCH: begin
          memAddrSelect = 1'b0;
          next_state    = S_DECODE;
        end
        S_DECODE: begin
          pcEnable            = 1'b1;
          pcSourceSelect      = 1'b0;
          srcAddressRegEnable = 1'b1;
          dstAddressRegEnable = 1'b1;
          immediateRegEnable  = 1'b1;
          // IR is loaded at the end of this cycle, so route on the incoming word.
          next_state          = decode_target(memReadData[15:0]);
        end
        S_EXECUTE: begin
          aluOutputRegEnable = 1'b1;
          aluInputBMuxSelect = ir_is_imm;
          next_state         = S_WRITEBACK;
        end
        S_WRITEBACK: begin
          regWriteEnable    = ~ir_is_cmp;
          regWriteSrcSelect = 1'b0;
          next_state        = S_FETCH;
        end
        S_MEM_ADDR: begin
          memAddrSelect = 1'b1;
          next_state    = S_MEM_WB;
        end
        S_MEM_WB: begin
          regWriteEnable    = 1'b1;
          regWriteSrcSelect = 1'b1;
          next_state        = S_FETCH;
        end
        S_STORE: begin
          memAddrSelect  = 1'b1;
          memWriteEnable = 1'b1;
          next_state     = S_FETCH;
        end
        S_BRANCH: begin
          // PC already advanced in DECODE, so PC+imm lands on addr+1+disp.
          if (branch_taken(ir[11:8], psr[0])) begin
            pcEnable       = 1'b1;
            pcSourceSelect = 1'b1;
          end else begin
            pcEnable       = 1'b0;
            pcSourceSelect = 1'b0;
          end
          next_state = S_FETCH;
        end
        S_HALT: begin
          halted     = 1'b1;
          next_state = S_HALT;
        end
        default: begin
          next_state = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: randomized self-checking bench for cpu_controller.
// A small environment (PC register and synchronous memory) reacts to the
// controller outputs; an instruction-level reference model predicts, for each
// instruction, the strobe pattern of every cycle, the decoded fields, the PSR
// and the address of the next fetch.
`timescale 1ns/1ps
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] memReadData;
  logic        carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag;
  logic [3:0]  aluOpCode;
  logic        instrType;
  logic [3:0]  regAddressA, regAddressB;
  logic [15:0] immediate;
  logic        srcAddressRegEnable, dstAddressRegEnable, immediateRegEnable, aluOutputRegEnable;
  logic        aluInputAMuxSelect, aluInputBMuxSelect;
  logic        regWriteEnable, regWriteSrcSelect, pcEnable, pcSourceSelect;
  logic        memAddrSelect, memWriteEnable, halted;

  cpu_controller #(.REG_WIDTH(16), .REG_ADDR_BITS(4)) dut (
    .clk(clk), .reset(reset), .memReadData(memReadData),
    .carryFlag(carryFlag), .lowFlag(lowFlag), .overflowFlag(overflowFlag),
    .negFlag(negFlag), .zeroFlag(zeroFlag),
    .aluOpCode(aluOpCode), .instrType(instrType),
    .regAddressA(regAddressA), .regAddressB(regAddressB), .immediate(immediate),
    .srcAddressRegEnable(srcAddressRegEnable), .dstAddressRegEnable(dstAddressRegEnable),
    .immediateRegEnable(immediateRegEnable), .aluOutputRegEnable(aluOutputRegEnable),
    .aluInputAMuxSelect(aluInputAMuxSelect), .aluInputBMuxSelect(aluInputBMuxSelect),
    .regWriteEnable(regWriteEnable), .regWriteSrcSelect(regWriteSrcSelect),
    .pcEnable(pcEnable), .pcSourceSelect(pcSourceSelect),
    .memAddrSelect(memAddrSelect), .memWriteEnable(memWriteEnable), .halted(halted)
  );

  always #5 clk = ~clk;

  // Strobe bit positions inside the packed observation vector.
  localparam logic [12:0] V_RWE  = 13'h1000;
  localparam logic [12:0] V_RWS  = 13'h0800;
  localparam logic [12:0] V_PCE  = 13'h0400;
  localparam logic [12:0] V_PCS  = 13'h0200;
  localparam logic [12:0] V_MAS  = 13'h0100;
  localparam logic [12:0] V_MWE  = 13'h0080;
  localparam logic [12:0] V_AOE  = 13'h0040;
  localparam logic [12:0] V_SRC  = 13'h0020;
  localparam logic [12:0] V_DST  = 13'h0010;
  localparam logic [12:0] V_IMM  = 13'h0008;
  localparam logic [12:0] V_BSEL = 13'h0004;
  localparam logic [12:0] V_HALT = 13'h0001;

  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_HALT = 5;

  logic [12:0] obs_vec;
  logic [28:0] obs_fields;
  assign obs_vec = {regWriteEnable, regWriteSrcSelect, pcEnable, pcSourceSelect,
                    memAddrSelect, memWriteEnable, aluOutputRegEnable,
                    srcAddressRegEnable, dstAddressRegEnable, immediateRegEnable,
                    aluInputBMuxSelect, aluInputAMuxSelect, halted};
  assign obs_fields = {aluOpCode, instrType, regAddressA, regAddressB, immediate};

  // Environment: PC register and synchronous instruction memory.
  logic [15:0] mem [0:255];
  logic [15:0] env_pc;
  logic [7:0]  env_addr;
  assign env_addr = memAddrSelect ? 8'hFF : env_pc[7:0];

  always @(posedge clk) begin
    memReadData <= mem[env_addr];
    if (reset) env_pc <= 16'd0;
    else if (pcEnable) env_pc <= pcSourceSelect ? env_pc + immediate : env_pc + 16'd1;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [4:0]  m_psr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [15:0] w);
    case (w[15:12])
      4'h0: return C_R;
      4'h4: return (w[7:4] == 4'h0) ? C_LD : ((w[7:4] == 4'h4) ? C_ST : C_HALT);
      4'hC: return C_BR;
      4'hF: return C_HALT;
      default: return C_I;
    endcase
  endfunction

  function automatic logic [28:0] exp_fields(input logic [15:0] w);
    logic [3:0] op;
    int c;
    c  = classify(w);
    op = (c == C_R) ? w[7:4] : ((c == C_I) ? w[15:12] : 4'd0);
    return {op, (c == C_I), w[3:0], w[11:8], {{8{w[7]}}, w[7:0]}};
  endfunction

  function automatic logic is_cmp(input logic [15:0] w);
    int c;
    c = classify(w);
    return ((c == C_R) && (w[7:4] == 4'hB)) || ((c == C_I) && (w[15:12] == 4'hB));
  endfunction

  function automatic logic taken(input logic [15:0] w, input logic [4:0] psr);
    if (w[11:8] == 4'h0) return psr[0];
    if (w[11:8] == 4'h1) return ~psr[0];
    return (w[11:8] == 4'hE);
  endfunction

  // Run one instruction from the model PC; rst_at >= 0 asserts reset in that
  // cycle of the instruction; fl >= 0 forces the ALU flags.
  task automatic run_instr(input logic [15:0] w, input int rst_at, input int fl);
    int          cls, len;
    logic [12:0] exp;
    logic [15:0] fw;
    cls = classify(w);
    len = (cls == C_ST || cls == C_BR) ? 3 : ((cls == C_HALT) ? 23 : 4);
    if (cls == C_HALT) rst_at = 22;
    mem[m_pc[7:0]] = w;
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      reset = (k == rst_at);
      {carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag} = (fl < 0) ? 5'($urandom) : 5'(fl);
      #1;
      if (reset) begin
        check_eq("reset_strobes", 32'(obs_vec), 32'd0);
        check_eq("reset_fields", 32'(obs_fields), 32'd0);
        m_pc = 16'd0; m_ir = 16'd0; m_psr = 5'd0;
        break;
      end
      exp = 13'd0;
      if (k == 1) exp = V_PCE | V_SRC | V_DST | V_IMM;
      else if (k >= 2) begin
        case (cls)
          C_R, C_I: exp = (k == 2) ? (V_AOE | ((cls == C_I) ? V_BSEL : 13'd0))
                                   : (is_cmp(w) ? 13'd0 : V_RWE);
          C_LD:     exp = (k == 2) ? V_MAS : (V_RWE | V_RWS);
          C_ST:     exp = V_MAS | V_MWE;
          C_BR:     exp = taken(w, m_psr) ? (V_PCE | V_PCS) : 13'd0;
          default:  exp = V_HALT;
        endcase
      end
      fw = (k < 2) ? m_ir : w;
      check_eq($sformatf("strobes_w%04h_c%0d", w, k), 32'(obs_vec), 32'(exp));
      check_eq($sformatf("fields_w%04h_c%0d", w, k), 32'(obs_fields), 32'(exp_fields(fw)));
      if (k == 0) check_eq("fetch_pc", 32'(env_pc), 32'(m_pc));
      if (k == 1) begin m_ir = w; m_pc = m_pc + 16'd1; end
      if (k == 2 && (cls == C_R || cls == C_I))
        m_psr = {carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag};
      if (k == 2 && cls == C_BR && taken(w, m_psr))
        m_pc = m_pc + {{8{w[7]}}, w[7:0]};
    end
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("reset_strobes", 32'(obs_vec), 32'd0);
    check_eq("reset_fields", 32'(obs_fields), 32'd0);
    m_pc = 16'd0; m_ir = 16'd0; m_psr = 5'd0;
  endtask

  function automatic logic [15:0] rand_word();
    int         r;
    logic [3:0] ra, rb, f, op, cond;
    r  = $urandom_range(0, 99);
    ra = 4'($urandom);
    rb = 4'($urandom);
    if (r < 25) begin
      f = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom);
      return {4'h0, rb, f, ra};
    end else if (r < 50) begin
      op = 4'($urandom);
      while (op == 4'h0 || op == 4'h4 || op == 4'hC || op == 4'hF) op = 4'($urandom);
      if ($urandom_range(0, 3) == 0) op = 4'hB;
      return {op, rb, 8'($urandom)};
    end else if (r < 62) begin
      return {4'h4, rb, 4'h0, ra};
    end else if (r < 72) begin
      return {4'h4, rb, 4'h4, ra};
    end else if (r < 92) begin
      case ($urandom_range(0, 3))
        0: cond = 4'h0;
        1: cond = 4'h1;
        2: cond = 4'hE;
        default: cond = 4'($urandom);
      endcase
      return {4'hC, cond, 8'($urandom)};
    end else if (r < 96) begin
      return {4'hF, 12'($urandom)};
    end else begin
      f = 4'($urandom);
      while (f == 4'h0 || f == 4'h4) f = 4'($urandom);
      return {4'h4, rb, f, ra};
    end
  endfunction

  initial begin
    {carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag} = 5'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    m_pc = 16'd0; m_ir = 16'd0; m_psr = 5'd0;
    @(posedge clk);
    reset_cycle();
    // Directed: ADD, ADDI -1
    run_instr(16'h0251, -1, -1);
    run_instr(16'h53FF, -1, -1);
    // CMP R1,R1 (Z=1) then BEQ +4 at address 1 -> next fetch at 6
    reset_cycle();
    run_instr(16'h01B1, -1, 1);
    run_instr(16'hC004, -1, -1);
    // Same with BNE -> not taken, next fetch at 2
    reset_cycle();
    run_instr(16'h01B1, -1, 1);
    run_instr(16'hC104, -1, -1);
    // LOAD then STOR
    run_instr(16'h4201, -1, -1);
    run_instr(16'h4241, -1, -1);
    // Reset during WRITEBACK, then BEQ sees the cleared PSR
    run_instr(16'h0251, 3, -1);
    run_instr(16'hC004, -1, -1);
    // Reset during STORE
    run_instr(16'h4241, 2, -1);
    // HALT and illegal memory extension, each followed by reset
    run_instr(16'hF000, -1, -1);
    run_instr(16'h4F81, -1, -1);
    // Randomized instruction stream
    for (int n = 0; n < 300; n++) run_instr(rand_word(), -1, -1);
    // Occasional random mid-instruction resets
    for (int n = 0; n < 20; n++) run_instr(rand_word(), $urandom_range(0, 3), -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Multicycle control FSM for the 16-bit CPU datapath; drives the datapath's register-file, ALU-mux, program-counter and memory controls.
- Fetches an instruction word from synchronous memory into an internal instruction register (IR) and decodes it.
- Sequences each instruction through fixed states.
- Holds a flag register (PSR) updated from the ALU flags and used for conditional branches.

Parameters:
REG_WIDTH, 16, data and instruction word width.
REG_ADDR_BITS, 4, register-address width; register fields are IR[11:8] and IR[3:0], truncated to REG_ADDR_BITS.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
memReadData  input  REG_WIDTH  memory read data; valid the cycle after the address is presented.
carryFlag, lowFlag, overflowFlag, negFlag, zeroFlag  input  1 each  ALU combinational flags.
aluOpCode  output  4  to the datapath's ALU control decoder.
instrType  output  1  0 = register form, 1 = immediate form.
regAddressA, regAddressB  output  REG_ADDR_BITS  source (IR[3:0]) and destination (IR[11:8]).
immediate  output  REG_WIDTH  IR[7:0] sign-extended.
srcAddressRegEnable, dstAddressRegEnable, immediateRegEnable, aluOutputRegEnable  output  1 each  datapath register enables.
aluInputAMuxSelect, aluInputBMuxSelect  output  1 each  0 = register read data, 1 = PC / immediate.
regWriteEnable  output  1  register-file write.
regWriteSrcSelect  output  1  0 = ALU result, 1 = memReadData.
pcEnable  output  1  PC load.
pcSourceSelect  output  1  0 = PC+1, 1 = PC+immediate.
memAddrSelect  output  1  0 = PC, 1 = regReadData1.
memWriteEnable  output  1  store strobe.
halted  output  1  high in HALT.

Behaviour:
Reset:
- State = FETCH; IR = 0; PSR = 0.
- All enables, write strobes and selects = 0; aluOpCode = 0; halted = 0.
- Reset asserted mid-instruction aborts it; no write or memory strobe is issued in the reset cycle.

Decode, from IR[15:12]:
- 0000: R-type; aluOpCode = IR[7:4]; instrType = 0.
- 0100: memory group. IR[7:4] = 0000 is LOAD, 0100 is STOR; any other value is illegal.
- 1100: Bcond.
- 1111: HALT.
- Any other opcode: immediate ALU op; aluOpCode = IR[15:12]; instrType = 1; aluInputBMuxSelect = 1.
- Compare (aluOpCode = 1011, both forms) never asserts regWriteEnable.

Outputs are Moore (decoded from state + IR).

FETCH:
- memAddrSelect = 0.
- Next state: DECODE.

DECODE:
- IR <= memReadData at the end of this cycle.
- pcEnable = 1, pcSourceSelect = 0.
- srcAddressRegEnable = dstAddressRegEnable = immediateRegEnable = 1.
- Next state by opcode: EXECUTE (R/I), MEM_ADDR (LOAD), STORE, BRANCH, HALT. Illegal opcodes go to HALT.

EXECUTE:
- aluOutputRegEnable = 1.
- PSR <= {carry, low, overflow, neg, zero}.
- Next state: WRITEBACK.

WRITEBACK:
- regWriteEnable = 1 unless compare; regWriteSrcSelect = 0.
- Next state: FETCH.

MEM_ADDR:
- memAddrSelect = 1.
- Next state: MEM_WB.

MEM_WB:
- regWriteEnable = 1, regWriteSrcSelect = 1.
- Next state: FETCH.

STORE:
- memAddrSelect = 1, memWriteEnable = 1 for exactly one cycle.
- Next state: FETCH.

BRANCH:
- Condition IR[11:8]: 0000 EQ (PSR.Z = 1); 0001 NE (PSR.Z = 0); 1110 always. All other codes are never taken.
- If taken: pcEnable = 1, pcSourceSelect = 1.
- Next state: FETCH.
- The displacement applies to the already-incremented PC (target = addr+1+disp).

HALT:
- halted = 1; all strobes 0; leaves only on reset.

Timing and PSR rules:
- Latency is 4 cycles for R/I/LOAD and 3 cycles for STOR/Bcond.
- PSR changes only in EXECUTE. It is unchanged by LOAD, STOR and Bcond.
- A compare followed by a branch uses the flags from the compare.

Test Plan:
- Memory[0] = 0x0251 (ADD R2,R1), R1 = 3, R2 = 4 → IR = 0x0251, aluOpCode = 0101, instrType = 0; regWriteEnable pulses once, 4 cycles after FETCH entry; PC = 1.
- Memory[0] = 0x53FF (ADDI R3,-1) → immediate = 0xFFFF, instrType = 1, aluInputBMuxSelect = 1 in EXECUTE; write in cycle 4.
- CMP R1,R1 (0x01B1), then BEQ +4 (0xC004) at address 1 → no register write for the compare; PSR.Z = 1; pcEnable with pcSourceSelect = 1 in BRANCH; next fetch at address 6. Repeat with BNE (0xC104) → not taken; next fetch at address 2.
- LOAD (0x4201) then STOR (0x4241) → LOAD: memAddrSelect = 1 in MEM_ADDR, regWriteSrcSelect = 1 with write in MEM_WB. STOR: exactly one memWriteEnable cycle; 3-cycle instruction.
- Opcode 0xF000, then 0x4F81 after reset → halted = 1 and held for 20 cycles with no strobes; 0x4F81 (illegal memory ext) also reaches HALT.
- Assert reset during WRITEBACK and during STORE → no regWriteEnable/memWriteEnable in that cycle; next cycle state = FETCH, PSR = 0, IR = 0.
